// File: rtl/btn_conditioner.sv
// Per-button 2-flop sync, counter debounce, one-cycle press pulse and auto-repeat.
// Latency: raw edge to btn_level/btn_pulse is 2 + DEBOUNCE_CYCLES edges; no backpressure, pulses are fire-and-forget.
module btn_conditioner #(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 150000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_raw,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_pulse
);

  localparam int DW       = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW       = $clog2(HOLD_MAX);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

  typedef enum logic {
    WAIT_DELAY = 1'b0,
    REPEATING  = 1'b1
  } rep_state_e;

  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic          s;
    logic          accept;
    logic          stable_q,   stable_d;
    logic [DW-1:0] db_cnt_q,   db_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    rep_state_e    state_q,    state_d;
    logic          pulse_q,    pulse_d;

    assign s      = sync2_q[i];
    assign accept = (s != stable_q) && (db_cnt_q == DB_LAST);

    always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      if (s == stable_q) begin
        db_cnt_d = '0;
      end else if (accept) begin
        stable_d = s;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // Only a steady hold with repeat enabled advances the timer; every other case parks it at zero.
    always_comb begin
      hold_cnt_d = '0;
      state_d    = WAIT_DELAY;
      pulse_d    = 1'b0;
      if (accept && s) begin
        pulse_d = 1'b1;
      end else if (stable_q && !accept && repeat_en[i]) begin
        if (state_q == WAIT_DELAY) begin
          if (hold_cnt_q == DELAY_LAST) begin
            pulse_d = 1'b1;
            state_d = REPEATING;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end else begin
          state_d = REPEATING;
          if (hold_cnt_q == RATE_LAST) begin
            pulse_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stable_q   <= 1'b0;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        state_q    <= WAIT_DELAY;
        pulse_q    <= 1'b0;
      end else begin
        stable_q   <= stable_d;
        db_cnt_q   <= db_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        state_q    <= state_d;
        pulse_q    <= pulse_d;
      end
    end

    assign btn_level[i] = stable_q;
    assign btn_pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncing, scored every cycle against a window/age model.
module tb_btn_conditioner;

  localparam int N  = 8;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] pls;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  // Model: hist[0] is the sample taken at this edge; the level flips once the
  // DB samples ending two edges ago all disagree with it. Repeat timing is the
  // age since the press (or since the last edge with repeat disabled).
  logic [N-1:0] hist [0:DB+1];
  logic [N-1:0] m_level = '0;
  int           anchor [N];

  always @(posedge clk) begin
    exp_t         e;
    logic [N-1:0] nxt;
    logic [N-1:0] pls;
    bit           flip;
    int           age;
    cyc++;
    e = '0;
    if (rst) begin
      for (int k = 0; k < DB + 2; k++) hist[k] = '0;
      for (int i = 0; i < N; i++) anchor[i] = 0;
      m_level = '0;
    end else begin
      for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = btn_raw;
      nxt = m_level;
      pls = '0;
      for (int i = 0; i < N; i++) begin
        flip = 1'b1;
        for (int k = 2; k < DB + 2; k++)
          if (hist[k][i] == m_level[i]) flip = 1'b0;
        if (flip) nxt[i] = ~m_level[i];
        if (!m_level[i] && nxt[i]) begin
          pls[i]    = 1'b1;
          anchor[i] = cyc;
        end else if (m_level[i] && nxt[i]) begin
          if (!repeat_en[i]) begin
            anchor[i] = cyc;
          end else begin
            age = cyc - anchor[i];
            if (age == RD || (age > RD && ((age - RD) % RR) == 0)) pls[i] = 1'b1;
          end
        end
      end
      m_level = nxt;
      e.lvl   = nxt;
      e.pls   = pls;
    end
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t req;
    vectors++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty at cycle %0d: no expected entry queued", cyc);
    end else begin
      e   = sb_q.pop_front();
      req = rst ? exp_t'('0) : e;
      if ({btn_level, btn_pulse} !== req) begin
        errors++;
        $display("FAIL sb cycle %0d: level=%h pulse=%h required level=%h pulse=%h",
                 cyc, btn_level, btn_pulse, req.lvl, req.pls);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Edges until the selected output bit reaches val; capped at 40.
  task automatic wait_bit(input int ch, input bit use_pulse, input logic val, output int n);
    n = 0;
    while (((use_pulse ? btn_pulse[ch] : btn_level[ch]) !== val) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    tick(3);
    rst = 1'b0;
    check("reset_outputs", int'({btn_level, btn_pulse}), 0);

    // Bounce on button 0: never three-plus-one stable samples in a row.
    btn_raw[0] = 1'b1; tick(3);
    btn_raw[0] = 1'b0; tick(1);
    btn_raw[0] = 1'b1; tick(3);
    btn_raw[0] = 1'b0; tick(12);
    check("bounce_level0", int'(btn_level[0]), 0);

    // Clean press and release on button 1.
    btn_raw[1] = 1'b1;
    wait_bit(1, 1'b1, 1'b1, n);
    check("press_latency", n, 6);
    check("press_level", int'(btn_level[1]), 1);
    tick(1);
    check("pulse_one_cycle", int'(btn_pulse[1]), 0);
    tick(5);
    btn_raw[1] = 1'b0;
    wait_bit(1, 1'b0, 1'b0, n);
    check("release_latency", n, 6);
    tick(8);

    // Auto-repeat on button 2 held ~30 cycles.
    repeat_en[2] = 1'b1;
    btn_raw[2]   = 1'b1;
    wait_bit(2, 1'b1, 1'b1, n);
    tick(1);
    wait_bit(2, 1'b1, 1'b1, n);
    check("first_repeat", n, RD - 1);
    tick(1);
    wait_bit(2, 1'b1, 1'b1, n);
    check("repeat_rate", n, RR - 1);
    tick(17);
    btn_raw[2] = 1'b0;
    tick(12);

    // Repeat disabled, then enabled 20 cycles after the press.
    repeat_en[2] = 1'b0;
    btn_raw[2]   = 1'b1;
    wait_bit(2, 1'b1, 1'b1, n);
    tick(20);
    repeat_en[2] = 1'b1;
    wait_bit(2, 1'b1, 1'b1, n);
    check("reenable_delay", n, RD);
    btn_raw[2]   = 1'b0;
    repeat_en[2] = 1'b0;
    tick(12);

    // Simultaneous presses.
    btn_raw[3] = 1'b1;
    btn_raw[7] = 1'b1;
    n = 0;
    while (btn_pulse == '0 && n < 40) begin tick(1); n++; end
    check("simul_pulse", int'(btn_pulse), 'h88);
    check("simul_level", int'(btn_level & 8'h88), 'h88);
    btn_raw = '0;
    tick(12);

    // Reset while repeating.
    repeat_en[4] = 1'b1;
    btn_raw[4]   = 1'b1;
    wait_bit(4, 1'b1, 1'b1, n);
    tick(12);
    rst = 1'b1;
    #1;
    check("async_reset", int'({btn_level, btn_pulse}), 0);
    tick(3);
    rst = 1'b0;
    wait_bit(4, 1'b1, 1'b1, n);
    check("press_after_reset", n, 6);
    btn_raw = '0;
    repeat_en = '0;
    tick(12);

    // Random bouncing, repeat toggling and occasional resets.
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      int bouncy;
      len    = $urandom_range(10, 50);
      bouncy = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) repeat_en = N'($urandom);
      for (int c = 0; c < len; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, (bouncy == 0) ? 2 : 40) == 0) btn_raw[i] = ~btn_raw[i];
        if ($urandom_range(0, 400) == 0) rst = 1'b1;
        else if (rst && $urandom_range(0, 1) == 0) rst = 1'b0;
        tick(1);
      end
    end
    rst = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
